// File: rtl/spi_frame_pkg.sv
// Shared types and constants for the SPI frame controller.
package spi_frame_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GET_ADDR,
    ST_READ_LOAD,
    ST_READ_SHIFT,
    ST_WRITE_SHIFT,
    ST_WRITE_COMMIT,
    ST_DONE
  } state_t;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/spi_shift_reg.sv
// Data shift register: synchronous clear, parallel load, left shift with
// serial input at the LSB and serial output from the MSB.
module spi_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift_en,
  input  logic             serial_in,
  output logic [WIDTH-1:0] data,
  output logic             serial_out
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data <= '0;
    end else if (clear) begin
      data <= '0;
    end else if (load) begin
      data <= load_data;
    end else if (shift_en) begin
      data <= {data[WIDTH-2:0], serial_in};
    end
  end

  assign serial_out = data[WIDTH-1];

endmodule

// File: rtl/spi_frame_controller.sv
// Frame-level SPI slave (mode 0, MSB first): address byte then data byte(s)
// onto a synchronous register file. Optional burst mode: define SPI_BURST_EN.
module spi_frame_controller
  import spi_frame_pkg::*;
#(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cs_n,
  input  logic                  sclk_posedge,
  input  logic                  sclk_negedge,
  input  logic                  mosi,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_wr_en,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  output logic                  miso,
  output logic                  miso_oe,
  output logic                  busy
);

  localparam int unsigned AB_W    = ADDR_WIDTH + 1;
  localparam int unsigned CNT_MAX = (AB_W > DATA_WIDTH) ? AB_W : DATA_WIDTH;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 2);

  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(AB_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);

  state_t                  state;
  logic [CNT_W-1:0]        bit_cnt;
  logic [ADDR_WIDTH-1:0]   addr_sr;
  logic [AB_W-1:0]         addr_next;
  logic                    pos;
  logic                    neg;
  logic                    abort;

  logic                    sr_clear;
  logic                    sr_load;
  logic                    sr_shift;
  logic                    sr_in;
  logic [DATA_WIDTH-1:0]   sr_data;
  logic                    sr_msb;

  // A coincident negedge is dropped so the posedge is always the one processed.
  assign pos       = sclk_posedge;
  assign neg       = sclk_negedge & ~sclk_posedge;
  assign addr_next = {addr_sr, mosi};
  assign abort     = cs_n && (state != ST_IDLE) && (state != ST_WRITE_COMMIT);

  always_comb begin
    sr_clear = 1'b0;
    sr_load  = 1'b0;
    sr_shift = 1'b0;
    sr_in    = 1'b0;
    if (!cs_n) begin
      unique case (state)
        ST_IDLE:        sr_clear = 1'b1;
        ST_READ_LOAD:   sr_load  = 1'b1;
        ST_WRITE_SHIFT: begin
          sr_shift = pos;
          sr_in    = mosi;
        end
        ST_READ_SHIFT:  sr_shift = neg && (bit_cnt != '0) && (bit_cnt <= DATA_LAST);
        default: ;
      endcase
    end
  end

  spi_shift_reg #(
    .WIDTH (DATA_WIDTH)
  ) u_shift_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (sr_clear),
    .load       (sr_load),
    .load_data  (mem_rd_data),
    .shift_en   (sr_shift),
    .serial_in  (sr_in),
    .data       (sr_data),
    .serial_out (sr_msb)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      bit_cnt  <= '0;
      addr_sr  <= '0;
      mem_addr <= '0;
      miso_oe  <= 1'b0;
    end else if (abort) begin
      state   <= ST_IDLE;
      miso_oe <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (!cs_n) begin
            state   <= ST_GET_ADDR;
            bit_cnt <= '0;
            addr_sr <= '0;
          end
        end

        ST_GET_ADDR: begin
          if (pos) begin
            addr_sr <= addr_next[ADDR_WIDTH-1:0];
            if (bit_cnt == ADDR_LAST) begin
              mem_addr <= addr_next[AB_W-1:1];
              bit_cnt  <= '0;
              unique case (addr_next[0])
                RW_READ:  state <= ST_READ_LOAD;
                RW_WRITE: state <= ST_WRITE_SHIFT;
              endcase
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
        end

        // mem_rd_data settles during this cycle and is captured on exit.
        ST_READ_LOAD: begin
          miso_oe <= 1'b1;
          bit_cnt <= '0;
          state   <= ST_READ_SHIFT;
        end

        ST_READ_SHIFT: begin
          if (pos) begin
            if (bit_cnt == DATA_LAST) begin
              miso_oe <= 1'b0;
              bit_cnt <= '0;
`ifdef SPI_BURST_EN
              mem_addr <= mem_addr + ADDR_WIDTH'(1);
              state    <= ST_READ_LOAD;
`else
              state    <= ST_DONE;
`endif
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
        end

        ST_WRITE_SHIFT: begin
          if (pos) begin
            if (bit_cnt == DATA_LAST) begin
              bit_cnt <= '0;
              state   <= ST_WRITE_COMMIT;
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
        end

        // The strobe is never cut short; cs_n only decides where we go next.
        ST_WRITE_COMMIT: begin
          bit_cnt <= '0;
          if (cs_n) begin
            state <= ST_IDLE;
          end else begin
`ifdef SPI_BURST_EN
            mem_addr <= mem_addr + ADDR_WIDTH'(1);
            state    <= ST_WRITE_SHIFT;
`else
            state    <= ST_DONE;
`endif
          end
        end

        ST_DONE: ;

        default: state <= ST_IDLE;
      endcase
    end
  end

  assign mem_wr_en   = (state == ST_WRITE_COMMIT);
  assign mem_wr_data = (state == ST_WRITE_COMMIT) ? sr_data : '0;
  assign miso        = sr_msb;
  assign busy        = (state != ST_IDLE);

endmodule

// File: tb/tb_spi_frame_controller.sv
// Randomized SPI frame stimulus against a frame-level model of the slave.
module tb_spi_frame_controller;

  localparam int AW = 7;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cs_n = 1'b1;
  logic          sclk_posedge = 1'b0;
  logic          sclk_negedge = 1'b0;
  logic          mosi = 1'b0;
  logic [DW-1:0] mem_rd_data;
  logic [AW-1:0] mem_addr;
  logic          mem_wr_en;
  logic [DW-1:0] mem_wr_data;
  logic          miso;
  logic          miso_oe;
  logic          busy;

  always #5 clk = ~clk;

  spi_frame_controller #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cs_n         (cs_n),
    .sclk_posedge (sclk_posedge),
    .sclk_negedge (sclk_negedge),
    .mosi         (mosi),
    .mem_rd_data  (mem_rd_data),
    .mem_addr     (mem_addr),
    .mem_wr_en    (mem_wr_en),
    .mem_wr_data  (mem_wr_data),
    .miso         (miso),
    .miso_oe      (miso_oe),
    .busy         (busy)
  );

  // Register file seen by the DUT (combinational read is valid within one clk).
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic          pre_en = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [DW-1:0] pre_data = '0;

  assign mem_rd_data = mem[mem_addr];

  always @(posedge clk) begin
    if (pre_en)         mem[pre_addr] <= pre_data;
    else if (mem_wr_en) mem[mem_addr] <= mem_wr_data;
  end

  // Model state: intended memory contents and writes the frames must produce.
  logic [DW-1:0] model_mem [0:(1<<AW)-1];
  logic [AW-1:0] exp_wa [$];
  logic [DW-1:0] exp_wd [$];
  int            wr_pulses = 0;
  int            half = 4;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pre_addr = a;
    pre_data = d;
    pre_en   = 1'b1;
    tick();
    pre_en   = 1'b0;
    model_mem[a] = d;
  endtask

  // Per-cycle compare: busy must follow the previous clk's cs_n, and every
  // write strobe must match the next expected write.
  logic prev_cs = 1'b1;
  bit   prev_valid = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("reset_outputs", {mem_addr, mem_wr_en, mem_wr_data, miso, miso_oe, busy}, 32'd0);
      prev_valid = 1'b0;
    end else begin
      if (prev_valid) begin
        chk("busy_vs_cs", busy, !prev_cs);
        if (prev_cs) chk("miso_oe_after_cs", miso_oe, 1'b0);
      end
      if (mem_wr_en) begin
        wr_pulses++;
        if (exp_wa.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write (t=%0t)",
                   mem_addr, mem_wr_data, $time);
        end else begin
          chk("wr_addr", mem_addr, exp_wa.pop_front());
          chk("wr_data", mem_wr_data, exp_wd.pop_front());
        end
      end
      prev_cs    = cs_n;
      prev_valid = 1'b1;
    end
  end

  // One SCLK period, mode 0: data set while low, master samples MISO at the rise.
  task automatic sclk_cycle(input logic b, input bit cs_rise, output logic m, output logic oe);
    mosi = b;
    repeat (half) tick();
    m  = miso;
    oe = miso_oe;
    sclk_posedge = 1'b1;
    if (cs_rise) cs_n = 1'b1;
    tick();
    sclk_posedge = 1'b0;
    repeat (half - 1) tick();
    sclk_negedge = 1'b1;
    tick();
    sclk_negedge = 1'b0;
  endtask

  task automatic do_frame(input logic [AW-1:0] a, input logic rd, input int nbytes,
                          input logic [DW-1:0] wd0, input logic [DW-1:0] wd1,
                          input int abort_bit, input bit cs_on_last,
                          output logic [DW-1:0] first_rd);
    logic [AW:0]   ab;
    logic          m, oe;
    logic [AW-1:0] cur;
    int            sent;
    bit            aborted;
    ab = {a, rd};
    cur = a;
    sent = 0;
    aborted = 1'b0;
    first_rd = '0;
    cs_n = 1'b0;
    repeat (half) tick();
    for (int i = AW; i >= 0; i--) sclk_cycle(ab[i], 1'b0, m, oe);
    for (int b = 0; b < nbytes && !aborted; b++) begin
      logic [DW-1:0] wd, ex, got;
      bit            active;
      wd  = (b == 0) ? wd0 : wd1;
      ex  = model_mem[cur];
      got = '0;
`ifdef SPI_BURST_EN
      active = 1'b1;
`else
      active = (b == 0);
`endif
      for (int i = DW - 1; i >= 0 && !aborted; i--) begin
        bit last;
        if (sent == abort_bit) begin
          aborted = 1'b1;
        end else begin
          last = cs_on_last && (b == nbytes - 1) && (i == 0);
          if (!rd && active && i == 0 && !last) begin
            exp_wa.push_back(cur);
            exp_wd.push_back(wd);
            model_mem[cur] = wd;
          end
          sclk_cycle(rd ? 1'($urandom) : wd[i], last, m, oe);
          sent++;
          if (rd) begin
            got[i] = m;
            if (active) begin
              chk("rd_miso_oe", oe, 1'b1);
              chk("rd_bit", m, ex[i]);
            end else begin
              chk("rd_oe_after_byte", oe, 1'b0);
            end
          end
        end
      end
      if (b == 0) first_rd = got;
      cur = cur + 1'b1;
    end
    cs_n = 1'b1;
    repeat (3) tick();
    chk("pending_writes", exp_wa.size(), 0);
    exp_wa.delete();
    exp_wd.delete();
  endtask

  initial begin
    #3_000_000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] got;
    logic [AW:0]   ab;
    logic          m, oe;
    int            w0;

    repeat (3) tick();
    chk("reset_busy", busy, 1'b0);
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < (1 << AW); i++) preload(AW'(i), DW'($urandom));

    // Write 0x5A to 0x12.
    w0 = wr_pulses;
    do_frame(7'h12, 1'b0, 1, 8'h5A, 8'h00, -1, 1'b0, got);
    chk("write_pulse_count", wr_pulses - w0, 1);
    chk("write_mem_12", mem[7'h12], 8'h5A);

    // Read 0x12 returning 0xA5.
    preload(7'h12, 8'hA5);
    w0 = wr_pulses;
    do_frame(7'h12, 1'b1, 1, 8'h00, 8'h00, -1, 1'b0, got);
    chk("read_byte_A5", got, 8'hA5);
    chk("read_no_write", wr_pulses - w0, 0);

    // Abort after 4 data bits, then cs_n rising with the final posedge.
    w0 = wr_pulses;
    do_frame(7'h30, 1'b0, 1, 8'hC3, 8'h00, 4, 1'b0, got);
    chk("abort_no_write", wr_pulses - w0, 0);
    w0 = wr_pulses;
    do_frame(7'h31, 1'b0, 1, 8'h3C, 8'h00, -1, 1'b1, got);
    chk("cs_last_no_write", wr_pulses - w0, 0);

    // Reset in the middle of a read, then a normal read.
    half = 4;
    ab = {7'h12, 1'b1};
    cs_n = 1'b0;
    repeat (half) tick();
    for (int i = AW; i >= 0; i--) sclk_cycle(ab[i], 1'b0, m, oe);
    for (int i = 0; i < 3; i++) sclk_cycle(1'b0, 1'b0, m, oe);
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", {mem_addr, mem_wr_en, mem_wr_data, miso, miso_oe, busy}, 32'd0);
    tick();
    cs_n = 1'b1;
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    do_frame(7'h12, 1'b1, 1, 8'h00, 8'h00, -1, 1'b0, got);
    chk("read_after_reset", got, 8'hA5);

    // Two-byte write at the top address.
    do_frame(7'h7F, 1'b0, 2, 8'h11, 8'h22, -1, 1'b0, got);
    chk("two_byte_first", mem[7'h7F], 8'h11);
`ifdef SPI_BURST_EN
    chk("burst_wrap_second", mem[7'h00], 8'h22);
`else
    chk("no_burst_addr0", mem[7'h00], model_mem[0]);
`endif

    // Randomized frames.
    for (int f = 0; f < 40; f++) begin
      logic          rd;
      int            nb, ab_bit;
      bit            csl;
      half   = $urandom_range(4, 6);
      rd     = 1'($urandom);
      nb     = $urandom_range(1, 2);
      ab_bit = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 8 * nb - 1) : -1;
      csl    = !rd && (ab_bit < 0) && ($urandom_range(0, 4) == 0);
      do_frame(AW'($urandom), rd, nb, DW'($urandom), DW'($urandom), ab_bit, csl, got);
      repeat ($urandom_range(1, 4)) tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
